// File: rtl/ult_sort4_seq_pkg.sv
// ult_sort4_seq_pkg: shared FSM encoding, element count and bubble pair schedule
package ult_sort4_seq_pkg;
  localparam int N = 4;
  localparam int NSTEPS = 6;
  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;
  localparam logic [1:0] PAIR_A [NSTEPS] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0};
  localparam logic [1:0] PAIR_B [NSTEPS] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd1};
endpackage

// File: rtl/ult_sort4_seq_ult4.sv
// ult_sort4_seq_ult4: 4-bit unsigned less-than, O = I0 < I1, as invert + carry chain + invert
module ult_sort4_seq_ult4 (
  input  logic [3:0] I0,
  input  logic [3:0] I1,
  output logic       O
);
  logic [4:0] sum;
  // I0 - I1 via I0 + ~I1 + 1; no carry out means a borrow, i.e. I0 < I1
  assign sum = {1'b0, I0} + {1'b0, ~I1} + 5'd1;
  assign O = ~sum[4];
endmodule

// File: rtl/ult_sort4_seq.sv
// ult_sort4_seq: 4-element ascending sorter time-sharing one ULT4 over a 6-step bubble schedule
module ult_sort4_seq
  import ult_sort4_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [2:0]         swap_count,
  output logic               busy
);
  state_t state, state_n;
  logic [2:0] step;
  logic [WIDTH-1:0] r [N];
  logic [1:0] pa, pb;
  logic lt;
  assign pa = PAIR_A[step];
  assign pb = PAIR_B[step];
  ult_sort4_seq_ult4 u_cmp (.I0(r[pb]), .I1(r[pa]), .O(lt));
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign out_data = {r[3], r[2], r[1], r[0]};
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (in_valid ? SORT : IDLE) :
              state == SORT ? (step == 3'(NSTEPS - 1) ? DONE : SORT) :
              (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      step <= '0;
      swap_count <= '0;
      for (int i = 0; i < N; i++) r[i] <= '0;
    end else if (state == IDLE && in_valid) begin
      step <= '0;
      swap_count <= '0;
      for (int i = 0; i < N; i++) r[i] <= in_data[i*WIDTH +: WIDTH];
    end else if (state == SORT) begin
      step <= step == 3'(NSTEPS - 1) ? 3'd0 : step + 3'd1;
      if (lt) begin
        r[pa] <= r[pb];
        r[pb] <= r[pa];
        swap_count <= swap_count + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_ult_sort4_seq.sv
// tb_ult_sort4_seq: directed vector table plus backpressure, reset-abort and back-to-back sequences
module tb_ult_sort4_seq;
  logic CLK = 0, RESET = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, busy;
  logic [15:0] in_data = '0, out_data;
  logic [2:0] swap_count;
  int checks = 0, errors = 0;

  ult_sort4_seq #(.WIDTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .swap_count(swap_count), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp;
    logic [2:0]  sc;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // call at a negedge in IDLE with out_ready=1; returns at a negedge back in IDLE
  task automatic run_vec(input string nm, input logic [15:0] din, input logic [15:0] exp, input logic [2:0] sc);
    int n;
    logic bad;
    n = 0;
    bad = 0;
    in_data = din;
    in_valid = 1;
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge CLK);
    do begin
      @(negedge CLK);
      in_valid = 0;
      n++;
      if (in_ready || !busy) bad = 1;
    end while (!out_valid && n < 20);
    chk({nm, " latency"}, n, 7);
    chk({nm, " busy/in_ready"}, 32'(bad), 32'd0);
    chk({nm, " data"}, 32'(out_data), 32'(exp));
    chk({nm, " swaps"}, 32'(swap_count), 32'(sc));
    @(negedge CLK);
    chk({nm, " idle"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    int n, acc_idx, res_idx, cyc;
    int acc_cyc [3];
    logic [15:0] held;
    logic bad;
    tbl[0] = '{16'h4321, 16'h4321, 3'd0};
    tbl[1] = '{16'h05AF, 16'hFA50, 3'd6};
    tbl[2] = '{16'h3133, 16'h3331, 3'd2};
    tbl[3] = '{16'hF0F0, 16'hFF00, 3'd1};
    tbl[4] = '{16'h5555, 16'h5555, 3'd0};
    tbl[5] = '{16'h3412, 16'h4321, 3'd2};
    tbl[6] = '{16'h7F08, 16'hF870, 3'd3};

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 0;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset swaps", 32'(swap_count), 32'd0);
    chk("reset data", 32'(out_data), 32'd0);

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), tbl[i].din, tbl[i].exp, tbl[i].sc);

    // backpressure: result frozen and input ignored while out_ready is low
    out_ready = 0;
    in_data = 16'h05AF;
    in_valid = 1;
    @(posedge CLK);
    n = 0;
    do begin
      @(negedge CLK);
      in_valid = 0;
      n++;
    end while (!out_valid && n < 20);
    chk("bp latency", n, 7);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      in_data = 16'h1234;
      @(negedge CLK);
      if (out_data !== 16'hFA50 || swap_count !== 3'd6 || in_ready || !out_valid) bad = 1;
    end
    chk("bp frozen", 32'(bad), 32'd0);
    in_valid = 0;
    out_ready = 1;
    @(negedge CLK);
    chk("bp release", {30'd0, in_ready, out_valid}, 32'b10);
    chk("bp data kept", 32'(out_data), 32'hFA50);

    // reset while SORT step 3 is executing
    in_data = 16'h05AF;
    in_valid = 1;
    @(posedge CLK);
    repeat (4) begin
      @(negedge CLK);
      in_valid = 0;
    end
    RESET = 1;
    @(negedge CLK);
    RESET = 0;
    chk("abort state", {28'd0, out_valid, busy, in_ready, 1'b0}, 32'b0010);
    chk("abort swaps", 32'(swap_count), 32'd0);
    chk("abort data", 32'(out_data), 32'd0);
    run_vec("after abort", 16'h1729, 16'h9721, 3'd5);

    // back-to-back with three queued vectors
    acc_idx = 0;
    res_idx = 0;
    cyc = 0;
    in_valid = 1;
    in_data = tbl[1].din;
    while (res_idx < 3 && cyc < 60) begin
      if (out_valid) begin
        chk($sformatf("b2b data%0d", res_idx), 32'(out_data), 32'(tbl[res_idx + 1].exp));
        chk($sformatf("b2b swaps%0d", res_idx), 32'(swap_count), 32'(tbl[res_idx + 1].sc));
        res_idx++;
      end
      if (in_ready && acc_idx < 3) begin
        in_data = tbl[acc_idx + 1].din;
        in_valid = 1;
        acc_cyc[acc_idx] = cyc;
        acc_idx++;
      end else if (acc_idx == 3 && in_ready) in_valid = 0;
      @(negedge CLK);
      cyc++;
    end
    in_valid = 0;
    chk("b2b results", res_idx, 3);
    chk("b2b accepts", acc_idx, 3);
    chk("b2b gap01", acc_cyc[1] - acc_cyc[0], 8);
    chk("b2b gap12", acc_cyc[2] - acc_cyc[1], 8);
    held = out_data;
    repeat (3) @(negedge CLK);
    chk("b2b no extra", {30'd0, busy, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
